// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the 5-stage pipeline sequencer:
//   - pipe_state_e : sequencer states (RUN=00, MEM_WAIT=01, ERR=10)
//   - PIPE_REG_W   : default register-address width
//   - X0           : the hard-wired zero register index
//   - pipe_ctl_t   : bundle of per-stage enables / flushes
//   - ctl_freeze / ctl_advance : canonical control patterns
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  localparam int PIPE_REG_W = 5;
  localparam int X0         = 0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERR      = 2'b10
  } pipe_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
    logic mem_wb_flush;
  } pipe_ctl_t;

  // Whole pipe holds while MEM waits; WB gets a bubble so the waiting
  // instruction is not written back twice.
  function automatic pipe_ctl_t ctl_freeze();
    pipe_ctl_t c;
    c              = '0;
    c.mem_wb_en    = 1'b1;
    c.mem_wb_flush = 1'b1;
    return c;
  endfunction

  // Normal advance; a redirect squashes the two younger stages and wins
  // over a load-use hazard (the dependent instruction is squashed anyway).
  function automatic pipe_ctl_t ctl_advance(input logic redirect, input logic load_use);
    pipe_ctl_t c;
    c           = '0;
    c.pc_en     = 1'b1;
    c.if_id_en  = 1'b1;
    c.id_ex_en  = 1'b1;
    c.ex_mem_en = 1'b1;
    c.mem_wb_en = 1'b1;
    if (redirect) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, inject one bubble into EX.
      c.pc_en       = 1'b0;
      c.if_id_en    = 1'b0;
      c.id_ex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard compare between the EX and ID stages.
// Ports:
//   ex_valid, ex_mem_rd, ex_rd   : EX instruction info (load, destination)
//   id_valid, id_rs1, id_rs2,
//   id_uses_rs2                  : ID instruction source operands
//   load_use                     : ID needs a value a load in EX has not produced
// ---------------------------------------------------------------------------
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W = PIPE_REG_W
) (
  input  logic             ex_valid,
  input  logic             ex_mem_rd,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  output logic             load_use
);

  logic rd_live;

  // x0 never carries a produced value, so it never creates a dependency.
  assign rd_live  = ex_valid & ex_mem_rd & (ex_rd != REG_W'(X0));
  assign load_use = rd_live & id_valid &
                    ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Pipeline sequencer for the 5-stage RV32I core: per-stage enables/flushes,
// load-use stalls, EX redirect flushes and the data-memory req/ack handshake
// with an optional MEM timeout into a sticky error state.
// Optional feature macro: PIPE_PERF_CNT_EN (adds stall_cnt / flush_cnt and the
// CNT_W parameter).
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   id_*/ex_*/mem_* inputs          : stage occupancy and operand info
//   ex_redirect                     : taken branch/jump resolved in EX
//   dmem_ack / dmem_req             : data-memory handshake
//   pc_en, *_en, *_flush            : per-stage register controls
//   mem_err                         : sticky timeout error
//   state                           : RUN=00, MEM_WAIT=01, ERR=10
//   stall_cnt, flush_cnt            : saturating perf counters (macro only)
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W       = PIPE_REG_W,
  parameter int MEM_TIMEOUT = 15
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic             ex_mem_rd,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_valid,
  input  logic             mem_mem_rd,
  input  logic             mem_mem_wr,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [1:0]       state
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  // Counter only needs to reach MEM_TIMEOUT-1; with MEM_TIMEOUT=0 it just wraps.
  localparam int               TO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  pipe_state_e     state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  pipe_ctl_t       ctl;
  logic            req;
  logic            redirect_fire;
  logic            mem_acc;
  logic            load_use;

  assign mem_acc = mem_valid & (mem_mem_rd | mem_mem_wr);

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .ex_valid    (ex_valid),
    .ex_mem_rd   (ex_mem_rd),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .load_use    (load_use)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    ctl           = '0;
    req           = 1'b0;
    redirect_fire = 1'b0;
    case (state_q)
      ST_RUN: begin
        // Zero-wait access (ack already high) advances without leaving RUN.
        req = mem_acc;
        if (mem_acc && !dmem_ack) begin
          ctl     = ctl_freeze();
          state_d = ST_MEM_WAIT;
          cnt_d   = '0;
        end else begin
          ctl           = ctl_advance(ex_redirect, load_use);
          redirect_fire = ex_redirect;
        end
      end
      ST_MEM_WAIT: begin
        req = 1'b1;
        if (dmem_ack) begin
          state_d       = ST_RUN;
          ctl           = ctl_advance(ex_redirect, load_use);
          redirect_fire = ex_redirect;
        end else begin
          ctl = ctl_freeze();
          if ((MEM_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_ERR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Gating with rst_n keeps every control low (and drops dmem_req) the
  // moment reset asserts, without waiting for a clock edge.
  assign dmem_req     = rst_n & req;
  assign pc_en        = rst_n & ctl.pc_en;
  assign if_id_en     = rst_n & ctl.if_id_en;
  assign if_id_flush  = rst_n & ctl.if_id_flush;
  assign id_ex_en     = rst_n & ctl.id_ex_en;
  assign id_ex_flush  = rst_n & ctl.id_ex_flush;
  assign ex_mem_en    = rst_n & ctl.ex_mem_en;
  assign mem_wb_en    = rst_n & ctl.mem_wb_en;
  assign mem_wb_flush = rst_n & ctl.mem_wb_flush;
  assign mem_err      = err_q;
  assign state        = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((state_q != ST_ERR) && !ctl.pc_en && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (redirect_fire && (flush_q != '1)) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench: directed scenarios followed by randomized traffic, all
// compared against a cycle-level behavioural model of the sequencer rules.
// Build with PIPE_PERF_CNT_EN defined to also check the perf counters.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int REG_W = 5;
  localparam int TO    = 4;
`ifdef PIPE_PERF_CNT_EN
  localparam int CW    = 3;
  localparam int CMAX  = (1 << CW) - 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             id_valid, id_uses_rs2, ex_valid, ex_mem_rd, ex_redirect;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             mem_valid, mem_mem_rd, mem_mem_wr, dmem_ack;
  logic             dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic             ex_mem_en, mem_wb_en, mem_wb_flush, mem_err;
  logic [1:0]       state;
`ifdef PIPE_PERF_CNT_EN
  logic [CW-1:0]    stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .REG_W       (REG_W),
    .MEM_TIMEOUT (TO)
`ifdef PIPE_PERF_CNT_EN
    ,
    .CNT_W       (CW)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs2  (id_uses_rs2),
    .ex_valid     (ex_valid),
    .ex_mem_rd    (ex_mem_rd),
    .ex_rd        (ex_rd),
    .ex_redirect  (ex_redirect),
    .mem_valid    (mem_valid),
    .mem_mem_rd   (mem_mem_rd),
    .mem_mem_wr   (mem_mem_wr),
    .dmem_ack     (dmem_ack),
    .dmem_req     (dmem_req),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_en     (id_ex_en),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .mem_wb_flush (mem_wb_flush),
    .mem_err      (mem_err),
    .state        (state)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 running, 1 waiting for memory, 2 error
  int m_mode, m_waits, m_stalls, m_flushes;
  bit m_err;

  task automatic model_reset();
    m_mode = 0; m_waits = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
  endtask

  function automatic bit access_now();
    return mem_valid && (mem_mem_rd || mem_mem_wr);
  endfunction

  function automatic bit frozen_now();
    if (m_mode == 1) return !dmem_ack;
    if (m_mode == 0) return access_now() && !dmem_ack;
    return 0;
  endfunction

  // {req, pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush}
  function automatic logic [8:0] model_outputs();
    bit hazard, req;
    hazard = ex_valid && ex_mem_rd && (ex_rd != 0) && id_valid &&
             ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    if (!rst_n || m_mode == 2) return 9'b0;
    req = (m_mode == 1) || access_now();
    if (frozen_now())  return {req, 8'b0000_0011};
    if (ex_redirect)   return {req, 8'b1111_1110};
    if (hazard)        return {req, 8'b0001_1110};
    return {req, 8'b1101_0110};
  endfunction

  task automatic model_advance(input logic [8:0] e);
    bit fz;
    fz = frozen_now();
    if (m_mode != 2 && !e[7]) m_stalls++;
    if (m_mode != 2 && !fz && ex_redirect) m_flushes++;
`ifdef PIPE_PERF_CNT_EN
    if (m_stalls > CMAX) m_stalls = CMAX;
    if (m_flushes > CMAX) m_flushes = CMAX;
`endif
    case (m_mode)
      0: if (fz) begin m_mode = 1; m_waits = 0; end
      1: begin
        if (dmem_ack) m_mode = 0;
        else if (TO != 0 && m_waits == TO - 1) begin m_mode = 2; m_err = 1; end
        else m_waits++;
      end
      default: ;
    endcase
  endtask

  // ---------------- cycle helpers ----------------
  logic [8:0] exp_vec;

  task automatic settle();
    #1;
    exp_vec = model_outputs();
    check("ctl", 32'({dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                      ex_mem_en, mem_wb_en, mem_wb_flush}), 32'(exp_vec));
    check("state", 32'(state), 32'(m_mode));
    check("mem_err", 32'(mem_err), 32'(m_err));
`ifdef PIPE_PERF_CNT_EN
    check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flushes));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_advance(exp_vec);
    @(negedge clk);
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  task automatic set_idle();
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 0;
    ex_valid = 0; ex_mem_rd = 0; ex_rd = '0; ex_redirect = 0;
    mem_valid = 0; mem_mem_rd = 0; mem_mem_wr = 0; dmem_ack = 0;
  endtask

  task automatic random_inputs();
    id_valid    = ($urandom_range(0, 3) != 0);
    id_rs1      = REG_W'($urandom_range(0, 3));
    id_rs2      = REG_W'($urandom_range(0, 3));
    id_uses_rs2 = ($urandom_range(0, 1) == 1);
    ex_valid    = ($urandom_range(0, 3) != 0);
    ex_mem_rd   = ($urandom_range(0, 1) == 1);
    ex_rd       = REG_W'($urandom_range(0, 3));
    ex_redirect = ($urandom_range(0, 4) == 0);
    mem_valid   = ($urandom_range(0, 1) == 1);
    mem_mem_rd  = ($urandom_range(0, 1) == 1);
    mem_mem_wr  = ($urandom_range(0, 2) == 0);
    dmem_ack    = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    set_idle();
    model_reset();
    @(negedge clk);

    // Reset holds every control low even with busy inputs.
    random_inputs(); mem_valid = 1; mem_mem_rd = 1;
    cycle(); cycle();
    rst_n = 1; set_idle();
    cycle();

    // Load-use: lw x5 in EX, add rs1=x5 in ID -> one bubble.
    ex_valid = 1; ex_mem_rd = 1; ex_rd = 5; id_valid = 1; id_rs1 = 5; id_rs2 = 1;
    settle(); check("lu_stall", 32'({pc_en, if_id_en, id_ex_flush}), 32'(3'b001)); tick();
    ex_valid = 0; ex_mem_rd = 0;
    settle(); check("lu_release", 32'({pc_en, if_id_en, id_ex_en}), 32'(3'b111)); tick();

    // ex_rd = x0, or rs2 match without rs2 use -> no stall.
    ex_valid = 1; ex_mem_rd = 1; ex_rd = 0; id_rs1 = 0;
    settle(); check("lu_x0", 32'(pc_en), 32'(1)); tick();
    ex_rd = 5; id_rs1 = 2; id_rs2 = 5; id_uses_rs2 = 0;
    settle(); check("lu_no_rs2", 32'(pc_en), 32'(1)); tick();

    // Redirect together with load-use: flush wins, no stall.
    id_rs1 = 5; ex_redirect = 1;
    settle(); check("redir_lu", 32'({pc_en, if_id_flush, id_ex_flush}), 32'(3'b111)); tick();
    set_idle();

    // Memory access acked after 3 wait cycles.
    mem_valid = 1; mem_mem_rd = 1;
    for (int i = 0; i < 3; i++) begin
      settle(); check("mw_freeze", 32'({dmem_req, pc_en, mem_wb_flush}), 32'(3'b101)); tick();
    end
    dmem_ack = 1;
    settle(); check("mw_ack", 32'({dmem_req, pc_en, state}), 32'(4'b1101)); tick();
    set_idle();

    // No ack: timeout into the sticky error state, then reset pulse.
    mem_valid = 1; mem_mem_wr = 1;
    for (int i = 0; i < 6; i++) cycle();
    settle(); check("err_state", 32'({state, mem_err, dmem_req}), 32'(4'b1010)); tick();
    rst_n = 0; model_reset();
    cycle();
    rst_n = 1; set_idle();
    settle(); check("err_cleared", 32'({state, mem_err}), 32'(3'b000)); tick();

    // Reset in the middle of MEM_WAIT drops the request immediately.
    mem_valid = 1; mem_mem_rd = 1;
    cycle(); cycle();
    rst_n = 0; model_reset();
    settle(); check("rst_drops_req", 32'(dmem_req), 32'(0)); tick();
    rst_n = 1; set_idle();
    cycle();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 0; model_reset();
      end else begin
        rst_n = 1;
      end
      random_inputs();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
